pe_token_scheduler: RTL and testbench

PE_TOKEN_SCHEDULER -- requirements
Module: pe_token_scheduler

---
 rtl/pe_token_scheduler.sv | 131 +++++++++++++
 tb/tb_pe_token_scheduler.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/pe_token_scheduler.sv
// PE token scheduler: gates ifmap/ipsum FIFO pops across the active PE columns
// through PREHEAT (staircase fill) and NORMAL (lockstep) phases, then drains and signals done.
module pe_token_scheduler (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start_i,
    input  logic [1:0]  layer_type_i,
    input  logic [5:0]  col_num_i,
    input  logic [15:0] loop_cnt_i,
    input  logic        use_ipsum_i,
    input  logic [31:0] ifmap_fifo_empty_matrix_i,
    input  logic [31:0] ipsum_fifo_empty_matrix_i,
    input  logic [31:0] ipsum_fifo_full_matrix_i,
    output logic        preheat_state_o,
    output logic        normal_loop_state_o,
    output logic [31:0] ifmap_fifo_pop_matrix_o,
    output logic [31:0] ipsum_fifo_pop_matrix_o,
    output logic [31:0] ipsum_fifo_push_matrix_o,
    output logic        busy_o,
    output logic        done_o
);
    localparam logic [2:0] IDLE    = 3'd0;
    localparam logic [2:0] PREHEAT = 3'd1;
    localparam logic [2:0] NORMAL  = 3'd2;
    localparam logic [2:0] DRAIN   = 3'd3;
    localparam logic [2:0] DONE    = 3'd4;

    logic [2:0]  state_q;
    logic [5:0]  col_q;
    logic [31:0] mask_q;
    logic [15:0] loop_q;
    logic        use_ipsum_q;
    logic [4:0]  p_q;
    logic [15:0] cnt_q;
    logic [31:0] push_q;

    logic [5:0]  col_clamped;
    logic [31:0] mask_new;
    logic [31:0] pre_req;
    logic        pre_fire;
    logic        norm_fire;

    always_comb begin
        col_clamped = (col_num_i > 6'd32) ? 6'd32 : col_num_i;
        mask_new    = '0;
        for (int unsigned i = 0; i < 32; i++) begin
            mask_new[i] = (i < 32'(col_clamped));
        end
    end

    // Preheat needs columns [p:0]; the shifted ~1 avoids a 33-bit shift when p=31.
    always_comb begin
        pre_req   = mask_q & ~(32'hFFFF_FFFE << p_q);
        pre_fire  = (state_q == PREHEAT) && ((ifmap_fifo_empty_matrix_i & pre_req) == '0);
        norm_fire = (state_q == NORMAL)
                 && ((ifmap_fifo_empty_matrix_i & mask_q) == '0)
                 && (!use_ipsum_q || ((ipsum_fifo_empty_matrix_i & mask_q) == '0))
                 && ((ipsum_fifo_full_matrix_i & mask_q) == '0);
    end

    always_comb begin
        ifmap_fifo_pop_matrix_o = '0;
        ipsum_fifo_pop_matrix_o = '0;
        if (pre_fire) begin
            ifmap_fifo_pop_matrix_o = pre_req;
        end else if (norm_fire) begin
            ifmap_fifo_pop_matrix_o = mask_q;
            ipsum_fifo_pop_matrix_o = use_ipsum_q ? mask_q : '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            col_q       <= '0;
            mask_q      <= '0;
            loop_q      <= '0;
            use_ipsum_q <= 1'b0;
            p_q         <= '0;
            cnt_q       <= '0;
            push_q      <= '0;
        end else begin
            push_q <= norm_fire ? mask_q : '0;
            case (state_q)
                IDLE: begin
                    if (start_i) begin
                        col_q       <= col_clamped;
                        mask_q      <= mask_new;
                        loop_q      <= loop_cnt_i;
                        use_ipsum_q <= use_ipsum_i;
                        p_q         <= '0;
                        cnt_q       <= '0;
                        if (col_clamped == '0 || loop_cnt_i == '0) begin
                            state_q <= DONE;
                        end else if (layer_type_i == 2'd1) begin
                            state_q <= NORMAL;
                        end else begin
                            state_q <= PREHEAT;
                        end
                    end
                end
                PREHEAT: begin
                    if (pre_fire) begin
                        p_q <= p_q + 5'd1;
                        if ({1'b0, p_q} == col_q - 6'd1) begin
                            state_q <= NORMAL;
                        end
                    end
                end
                NORMAL: begin
                    if (norm_fire) begin
                        cnt_q <= cnt_q + 16'd1;
                        if (cnt_q == loop_q - 16'd1) begin
                            state_q <= DRAIN;
                        end
                    end
                end
                DRAIN:   state_q <= DONE;
                DONE:    state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

    assign ipsum_fifo_push_matrix_o = push_q;
    assign preheat_state_o          = (state_q == PREHEAT);
    assign normal_loop_state_o      = (state_q == NORMAL);
    assign busy_o                   = (state_q == PREHEAT) || (state_q == NORMAL) || (state_q == DRAIN);
    assign done_o                   = (state_q == DONE);

endmodule

// File: tb/tb_pe_token_scheduler.sv
// Bench for pe_token_scheduler: table of launch configurations plus stall, mid-run start
// and reset sequences; expected pops are queued at launch and consumed as the DUT pops.
module tb_pe_token_scheduler;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start_i = 1'b0;
    logic [1:0]  layer_type_i = '0;
    logic [5:0]  col_num_i = '0;
    logic [15:0] loop_cnt_i = '0;
    logic        use_ipsum_i = 1'b0;
    logic [31:0] ifmap_empty = '0;
    logic [31:0] ipsum_empty = '0;
    logic [31:0] ipsum_full = '0;
    logic        preheat_state_o, normal_loop_state_o, busy_o, done_o;
    logic [31:0] ifmap_pop, ipsum_pop, push;

    pe_token_scheduler dut (
        .clk                       (clk),
        .rst_n                     (rst_n),
        .start_i                   (start_i),
        .layer_type_i              (layer_type_i),
        .col_num_i                 (col_num_i),
        .loop_cnt_i                (loop_cnt_i),
        .use_ipsum_i               (use_ipsum_i),
        .ifmap_fifo_empty_matrix_i (ifmap_empty),
        .ipsum_fifo_empty_matrix_i (ipsum_empty),
        .ipsum_fifo_full_matrix_i  (ipsum_full),
        .preheat_state_o           (preheat_state_o),
        .normal_loop_state_o       (normal_loop_state_o),
        .ifmap_fifo_pop_matrix_o   (ifmap_pop),
        .ipsum_fifo_pop_matrix_o   (ipsum_pop),
        .ipsum_fifo_push_matrix_o  (push),
        .busy_o                    (busy_o),
        .done_o                    (done_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  layer;
        logic [5:0]  col;
        logic [15:0] loops;
        logic        use_ipsum;
        logic [31:0] mask;
        int          pre_n;
    } vec_t;

    typedef struct {
        logic [31:0] ifmap;
        logic [31:0] ipsum;
    } pop_t;

    pop_t        sb[$];
    int          n_checks = 0;
    int          n_fail = 0;
    int          cyc_n = 0;
    int          nfires, normal_fires, done_cyc, done_cnt;
    logic        prev_nfire = 1'b0;
    logic        stalling = 1'b0;
    logic [31:0] cur_mask = '0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc_n);
        end
    endtask

    task automatic monitor();
        pop_t e;
        if (ifmap_pop != '0) begin
            if (sb.size() == 0) begin
                chk("extra_pop", ifmap_pop, '0);
            end else begin
                e = sb.pop_front();
                chk("ifmap_pop", ifmap_pop, e.ifmap);
                chk("ipsum_pop", ipsum_pop, e.ipsum);
            end
            nfires++;
        end else begin
            chk("ipsum_pop_no_fire", ipsum_pop, '0);
        end
        if (stalling) begin
            chk("stall_pop", ifmap_pop, '0);
            chk("stall_normal_flag", {31'b0, normal_loop_state_o}, 32'd1);
        end
        chk("push", push, prev_nfire ? cur_mask : '0);
        if (normal_loop_state_o && ifmap_pop != '0) normal_fires++;
        prev_nfire = normal_loop_state_o && (ifmap_pop != '0);
        if (done_o) begin
            done_cnt++;
            if (done_cyc < 0) done_cyc = cyc_n;
        end
    endtask

    task automatic cyc();
        @(negedge clk);
        monitor();
        @(posedge clk);
        #1;
        cyc_n++;
    endtask

    // stall_kind: 1 = ifmap column 2 empty, 2 = ipsum column 0 full (both with a mid-run start)
    task automatic run(input vec_t v, input int stall_kind, input int stall_at,
                       input int stall_len, input int abort_at);
        int   s, stall_left, exp_off;
        logic deg;
        pop_t e;
        sb.delete();
        nfires = 0; normal_fires = 0; done_cyc = -1; done_cnt = 0;
        prev_nfire = 1'b0; stalling = 1'b0;
        cur_mask = v.mask;
        deg = (v.mask == '0) || (v.loops == '0);
        for (int p = 0; p < v.pre_n; p++) begin
            e.ifmap = (p == 31) ? 32'hFFFF_FFFF : ((32'h1 << (p + 1)) - 32'h1);
            e.ipsum = '0;
            sb.push_back(e);
        end
        if (!deg) begin
            for (int i = 0; i < int'(v.loops); i++) begin
                e.ifmap = v.mask;
                e.ipsum = v.use_ipsum ? v.mask : '0;
                sb.push_back(e);
            end
        end
        exp_off = deg ? 1 : v.pre_n + int'(v.loops) + 2 + stall_len;

        layer_type_i = v.layer; col_num_i = v.col; loop_cnt_i = v.loops;
        use_ipsum_i = v.use_ipsum; start_i = 1'b1;
        s = cyc_n;
        cyc();
        start_i = 1'b0;
        stall_left = stall_len;
        for (int i = 0; i < 400 && done_cyc < 0; i++) begin
            if (abort_at >= 0 && normal_fires == abort_at) begin
                rst_n = 1'b0;
                #1;
                chk("rst_push", push, '0);
                chk("rst_ifmap_pop", ifmap_pop, '0);
                chk("rst_busy", {31'b0, busy_o}, '0);
                chk("rst_normal_flag", {31'b0, normal_loop_state_o}, '0);
                chk("rst_done", {31'b0, done_o}, '0);
                @(posedge clk);
                #1;
                rst_n = 1'b1;
                prev_nfire = 1'b0;
                sb.delete();
                repeat (3) cyc();
                chk("idle_after_rst", {30'b0, busy_o, preheat_state_o}, '0);
                return;
            end
            if (stall_kind != 0 && normal_loop_state_o && normal_fires == stall_at && stall_left > 0) begin
                stalling = 1'b1;
                stall_left--;
                if (stall_kind == 1) ifmap_empty = 32'h4;
                else ipsum_full = 32'h1;
                start_i = 1'b1; col_num_i = 6'd3; layer_type_i = 2'd1; loop_cnt_i = 16'd9;
            end else begin
                stalling = 1'b0; ifmap_empty = '0; ipsum_full = '0; start_i = 1'b0;
            end
            cyc();
        end
        stalling = 1'b0; start_i = 1'b0; ifmap_empty = '0; ipsum_full = '0;
        chk("done_seen", {31'b0, done_cyc >= 0}, 32'd1);
        chk("done_latency", 32'(done_cyc - s), 32'(exp_off));
        chk("fire_total", 32'(nfires), 32'(v.pre_n + (deg ? 0 : int'(v.loops))));
        chk("sb_empty", 32'(sb.size()), '0);
        cyc();
        chk("done_width", 32'(done_cnt), 32'd1);
        chk("idle_flags", {28'b0, busy_o, done_o, preheat_state_o, normal_loop_state_o}, '0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t tbl[6];
        tbl[0] = '{2'd0, 6'd4,  16'd3, 1'b1, 32'h0000_000F, 4};
        tbl[1] = '{2'd1, 6'd32, 16'd2, 1'b0, 32'hFFFF_FFFF, 0};
        tbl[2] = '{2'd2, 6'd5,  16'd2, 1'b1, 32'h0000_001F, 5};
        tbl[3] = '{2'd3, 6'd40, 16'd1, 1'b0, 32'hFFFF_FFFF, 32};
        tbl[4] = '{2'd0, 6'd0,  16'd3, 1'b1, 32'h0000_0000, 0};
        tbl[5] = '{2'd1, 6'd4,  16'd0, 1'b1, 32'h0000_0000, 0};

        repeat (2) @(posedge clk);
        #1;
        chk("reset_flags", {28'b0, busy_o, done_o, preheat_state_o, normal_loop_state_o}, '0);
        chk("reset_push", push, '0);
        chk("reset_pop", ifmap_pop | ipsum_pop, '0);
        rst_n = 1'b1;
        cyc();
        cyc();
        chk("idle_no_start", {31'b0, busy_o}, '0);

        for (int i = 0; i < 6; i++) begin
            run(tbl[i], 0, 0, 0, -1);
        end

        run('{2'd0, 6'd8, 16'd4, 1'b1, 32'h0000_00FF, 8}, 1, 1, 5, -1);
        run('{2'd1, 6'd6, 16'd4, 1'b1, 32'h0000_003F, 0}, 2, 2, 3, -1);
        run('{2'd1, 6'd6, 16'd5, 1'b0, 32'h0000_003F, 0}, 0, 0, 0, 2);
        run('{2'd1, 6'd6, 16'd5, 1'b0, 32'h0000_003F, 0}, 0, 0, 0, -1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
